// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants for the pipelined CORDIC rotator: the
//                arctangent table (2^32 units per full turn), the guard-bit
//                count of the x/y datapath and the Q2.30 CORDIC gain.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Extra integer bits on x/y: absorb the ~1.647 CORDIC gain and the
    // negation of the most negative input during pre-rotation.
    localparam int GW = 2;

    localparam int ATAN_ENTRIES = 32;

    // ATAN[i] = round(atan(2^-i) * 2^32 / (2*pi)); a full circle is 2^32.
    localparam logic [31:0] ATAN [ATAN_ENTRIES] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // Converged CORDIC gain K = 1.6467602581... in Q2.30.
    localparam logic [31:0] K_Q30 = 32'd1768195363;

endpackage
`default_nettype wire

// File: rtl/cordic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_stage
//  Description : One registered CORDIC micro-rotation. Rotates (x, y) by
//                +/- atan(2^-SHIFT) towards driving the residual angle z to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [DW+GW-1:0] x_in,
    input  logic [DW+GW-1:0] y_in,
    input  logic [DW-1:0]    z_in,
    output logic             valid_out,
    output logic [DW+GW-1:0] x_out,
    output logic [DW+GW-1:0] y_out,
    output logic [DW-1:0]    z_out
);

    // Table is in 32-bit angle units; narrower angle words drop LSBs.
    localparam logic [DW-1:0] ANGLE = DW'(ATAN[SHIFT] >> (32 - DW));

    logic                    w_rotate_pos;
    logic signed [DW+GW-1:0] w_x_shift;
    logic signed [DW+GW-1:0] w_y_shift;

    assign w_rotate_pos = ~z_in[DW-1];
    assign w_x_shift    = $signed(x_in) >>> SHIFT;
    assign w_y_shift    = $signed(y_in) >>> SHIFT;

    // Micro-rotation register: direction chosen by the sign of the residual angle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            valid_out <= valid_in;
            if (w_rotate_pos) begin
                x_out <= x_in - w_y_shift;
                y_out <= y_in + w_x_shift;
                z_out <= z_in - ANGLE;
            end else begin
                x_out <= x_in + w_y_shift;
                y_out <= y_in - w_x_shift;
                z_out <= z_in + ANGLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rotator
//  Description : Fully pipelined CORDIC rotation engine. Registered
//                pre-rotation folds the angle into [-90, 90) degrees, then
//                ITERATIONS micro-rotation stages follow; x/y are saturated
//                back to DW bits at the output. Latency ITERATIONS+1 cycles,
//                one sample per clock, no stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 23,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] z_in,
    output logic          valid_out,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic [DW-1:0] z_out
);

    localparam int XW = DW + GW;

    // Clamp a guard-extended value back into the signed DW-bit range.
    function automatic logic [DW-1:0] saturate(input logic [XW-1:0] v);
        if (v[XW-1:DW-1] == {(GW + 1){v[XW-1]}}) begin
            return v[DW-1:0];
        end else if (v[XW-1]) begin
            return {1'b1, {(DW - 1){1'b0}}};
        end else begin
            return {1'b0, {(DW - 1){1'b1}}};
        end
    endfunction

    // Angles in [90, 270) degrees have differing top two bits.
    logic          w_pre_rotate;
    logic [XW-1:0] w_x_ext;
    logic [XW-1:0] w_y_ext;

    assign w_pre_rotate = z_in[DW-1] ^ z_in[DW-2];
    assign w_x_ext      = {{GW{x_in[DW-1]}}, x_in};
    assign w_y_ext      = {{GW{y_in[DW-1]}}, y_in};

    logic          r_valid_pre;
    logic [XW-1:0] r_x_pre;
    logic [XW-1:0] r_y_pre;
    logic [DW-1:0] r_z_pre;

    // Pre-rotation by 180 degrees: negate x/y, flip the angle MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_pre <= 1'b0;
            r_x_pre     <= '0;
            r_y_pre     <= '0;
            r_z_pre     <= '0;
        end else begin
            r_valid_pre <= valid_in;
            if (w_pre_rotate) begin
                r_x_pre <= -w_x_ext;
                r_y_pre <= -w_y_ext;
                r_z_pre <= {~z_in[DW-1], z_in[DW-2:0]};
            end else begin
                r_x_pre <= w_x_ext;
                r_y_pre <= w_y_ext;
                r_z_pre <= z_in;
            end
        end
    end

    logic          w_valid_pipe [ITERATIONS];
    logic [XW-1:0] w_x_pipe     [ITERATIONS];
    logic [XW-1:0] w_y_pipe     [ITERATIONS];
    logic [DW-1:0] w_z_pipe     [ITERATIONS];

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
        logic          w_stage_valid;
        logic [XW-1:0] w_stage_x;
        logic [XW-1:0] w_stage_y;
        logic [DW-1:0] w_stage_z;

        if (i == 0) begin : g_head
            assign w_stage_valid = r_valid_pre;
            assign w_stage_x     = r_x_pre;
            assign w_stage_y     = r_y_pre;
            assign w_stage_z     = r_z_pre;
        end else begin : g_body
            assign w_stage_valid = w_valid_pipe[i-1];
            assign w_stage_x     = w_x_pipe[i-1];
            assign w_stage_y     = w_y_pipe[i-1];
            assign w_stage_z     = w_z_pipe[i-1];
        end

        cordic_stage #(
            .SHIFT (i),
            .DW    (DW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_in  (w_stage_valid),
            .x_in      (w_stage_x),
            .y_in      (w_stage_y),
            .z_in      (w_stage_z),
            .valid_out (w_valid_pipe[i]),
            .x_out     (w_x_pipe[i]),
            .y_out     (w_y_pipe[i]),
            .z_out     (w_z_pipe[i])
        );
    end

    assign valid_out = w_valid_pipe[ITERATIONS-1];
    assign x_out     = saturate(w_x_pipe[ITERATIONS-1]);
    assign y_out     = saturate(w_y_pipe[ITERATIONS-1]);
    assign z_out     = w_z_pipe[ITERATIONS-1];

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_rotator
//  Description : Directed and streaming checks of cordic_rotator against a
//                floating-point rotation model. The model follows the
//                micro-rotation angle sequence so its reference is the exact
//                rotation the pipeline should realise, up to truncation noise.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cordic_rotator;
    import cordic_pkg::*;

    localparam int     ITER   = 23;
    localparam int     LAT    = ITER + 1;
    localparam real    TWO_PI = 6.283185307179586;
    localparam longint TOL    = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [31:0] z_in;
    logic        valid_out;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [31:0] z_out;

    int     n_vec = 0;
    int     n_err = 0;
    longint atan_t [ITER];
    real    k_gain;

    logic        h_v [512];
    logic [31:0] h_x [512];
    logic [31:0] h_y [512];
    logic [31:0] h_z [512];

    always #5 clk = ~clk;

    cordic_rotator #(
        .ITERATIONS (ITER),
        .DW         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .valid_out (valid_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp);
        longint diff;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        n_vec++;
        assert ((diff <= TOL) === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
        end
    endtask

    function automatic longint to_sat(input real r);
        if (r >= 2147483647.0) return 64'sd2147483647;
        if (r <= -2147483648.0) return -64'sd2147483648;
        return longint'(r);
    endfunction

    // Reference: fold to [-90, 90), walk the residual angle through the
    // arctangent sequence, then rotate exactly by the angle actually consumed.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         output longint ex, output longint ey, output longint ez);
        int  zs;
        int  zr;
        real xs;
        real ys;
        real th;
        xs = real'($signed(x));
        ys = real'($signed(y));
        if (z[31] ^ z[30]) begin
            xs = -xs;
            ys = -ys;
            zs = $signed(z ^ 32'h8000_0000);
        end else begin
            zs = $signed(z);
        end
        zr = zs;
        for (int i = 0; i < ITER; i++) begin
            if (zr >= 0) zr = zr - int'(atan_t[i]);
            else         zr = zr + int'(atan_t[i]);
        end
        th = real'(longint'(zs) - longint'(zr)) * TWO_PI / 4294967296.0;
        ex = to_sat(k_gain * (xs * $cos(th) - ys * $sin(th)));
        ey = to_sat(k_gain * (xs * $sin(th) + ys * $cos(th)));
        ez = longint'(zr);
    endtask

    // One isolated sample: silent for LAT-1 cycles, one-cycle valid pulse.
    task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, output longint ox, output longint oy);
        longint ex;
        longint ey;
        longint ez;
        model(x, y, z, ex, ey, ez);
        valid_in = 1'b1;
        x_in     = x;
        y_in     = y;
        z_in     = z;
        tick();
        valid_in = 1'b0;
        repeat (LAT - 2) tick();
        chk($sformatf("%s early", tag), valid_out, 0);
        tick();
        chk($sformatf("%s valid", tag), valid_out, 1);
        ox = longint'($signed(x_out));
        oy = longint'($signed(y_out));
        chk_tol($sformatf("%s x", tag), ox, ex);
        chk_tol($sformatf("%s y", tag), oy, ey);
        chk($sformatf("%s z", tag), $signed(z_out), ez);
        tick();
        chk($sformatf("%s pulse", tag), valid_out, 0);
    endtask

    initial begin
        longint ox;
        longint oy;
        longint ex;
        longint ey;
        longint ez;
        int     sent;
        int     last_c;
        int     k;

        for (int i = 0; i < ITER; i++) begin
            atan_t[i] = longint'($atan(1.0 / real'(longint'(1) << i)) * 4294967296.0 / TWO_PI);
        end
        k_gain = real'(K_Q30) / 1073741824.0;

        rst_n    = 1'b1;
        valid_in = 1'b0;
        x_in     = '0;
        y_in     = '0;
        z_in     = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset valid_out", valid_out, 0);
        chk("reset x_out", {32'd0, x_out}, 0);
        chk("reset y_out", {32'd0, y_out}, 0);
        chk("reset z_out", {32'd0, z_out}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        run_vec("z0",    32'h1000_0000, 32'h0, 32'h0000_0000, ox, oy);
        run_vec("z45",   32'h1000_0000, 32'h0, 32'h2000_0000, ox, oy);
        run_vec("z90",   32'h1000_0000, 32'h0, 32'h4000_0000, ox, oy);
        run_vec("z180",  32'h1000_0000, 32'h0, 32'h8000_0000, ox, oy);
        run_vec("z270",  32'h1000_0000, 32'h0, 32'hC000_0000, ox, oy);
        run_vec("z135",  32'hF000_0000, 32'h0800_0000, 32'h6000_0000, ox, oy);
        run_vec("sat45", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, ox, oy);
        chk("sat45 y clamp", oy, 64'sd2147483647);
        run_vec("negmin", 32'h8000_0000, 32'h0, 32'h8000_0000, ox, oy);
        chk("negmin x clamp", ox, 64'sd2147483647);

        // Streaming with random bubbles; output valid must be the input
        // pattern delayed by LAT cycles.
        sent   = 0;
        last_c = -1000;
        for (int c = 0; c < 500; c++) begin
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                valid_in = 1'b1;
                x_in     = 32'($urandom_range(0, 32'h4000_0000)) - 32'h2000_0000;
                y_in     = 32'($urandom_range(0, 32'h4000_0000)) - 32'h2000_0000;
                z_in     = $urandom;
                sent++;
                last_c = c;
            end else begin
                valid_in = 1'b0;
                x_in     = $urandom;
                y_in     = $urandom;
                z_in     = $urandom;
            end
            h_v[c] = valid_in;
            h_x[c] = x_in;
            h_y[c] = y_in;
            h_z[c] = z_in;
            tick();
            if (c >= LAT - 1) begin
                k = c - LAT + 1;
                chk("stream valid", valid_out, h_v[k]);
                if (h_v[k]) begin
                    model(h_x[k], h_y[k], h_z[k], ex, ey, ez);
                    chk_tol("stream x", longint'($signed(x_out)), ex);
                    chk_tol("stream y", longint'($signed(y_out)), ey);
                    chk("stream z", $signed(z_out), ez);
                end
            end else begin
                chk("stream valid", valid_out, 0);
            end
            if (sent == 100 && c >= last_c + LAT) break;
        end

        // Reset with samples in flight: everything in the pipe is dropped.
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            x_in     = 32'h0123_4567 + 32'(i);
            y_in     = 32'h0765_4321;
            z_in     = $urandom;
            tick();
        end
        valid_in = 1'b0;
        x_in     = '0;
        y_in     = '0;
        z_in     = '0;
        rst_n    = 1'b0;
        #1;
        chk("midrst valid_out", valid_out, 0);
        chk("midrst x_out", {32'd0, x_out}, 0);
        chk("midrst y_out", {32'd0, y_out}, 0);
        chk("midrst z_out", {32'd0, z_out}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("postrst valid", valid_out, 0);
        end
        chk("postrst x_out", {32'd0, x_out}, 0);
        chk("postrst y_out", {32'd0, y_out}, 0);

        run_vec("afterrst", 32'h0800_0000, 32'h0400_0000, 32'hE000_0000, ox, oy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
